// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU issue sequencer and decode: opcodes, FSM states, datapath width.
package alu_seq_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    DONE
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Issue-side ALU controller: registers a request, drives the external ALU for one cycle
// (logic/arith ops) or for MUL_STEPS shift-add cycles (multiply), then holds the response
// until the consumer takes it.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = alu_seq_pkg::WIDTH,
  parameter int unsigned MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_ovfl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ovfl,
  output logic             rsp_err
);

  localparam int unsigned StepW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(MUL_STEPS - 1);

  seq_state_t       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [StepW-1:0] step_q, step_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             ovfl_q, ovfl_d;
  logic             err_q, err_d;

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      step_q   <= '0;
      sticky_q <= 1'b0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      ovfl_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      step_q   <= step_d;
      sticky_q <= sticky_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      ovfl_q   <= ovfl_d;
      err_q    <= err_d;
    end
  end

  // ALU drive: operands only in EXEC/MUL, quiet zeros otherwise.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_AND;
    unique case (state_q)
      EXEC: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = op_q;
      end
      MUL: begin
        // One shift-add step: acc + (multiplier LSB ? shifted multiplicand : 0).
        alu_a  = acc_q;
        alu_b  = mplr_q[0] ? mcand_q : '0;
        alu_op = OP_ADD;
      end
      default: ;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    step_d   = step_q;
    sticky_d = sticky_q;
    data_d   = data_q;
    zero_d   = zero_q;
    ovfl_d   = ovfl_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          case (req_op)
            OP_MUL: begin
              acc_d    = '0;
              mcand_d  = req_a;
              mplr_d   = req_b;
              step_d   = '0;
              sticky_d = 1'b0;
              state_d  = MUL;
            end
            OP_RSV: begin
              data_d  = '0;
              zero_d  = 1'b1;
              ovfl_d  = 1'b0;
              err_d   = 1'b1;
              state_d = DONE;
            end
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        data_d  = alu_r;
        zero_d  = alu_zero;
        ovfl_d  = alu_ovfl;
        err_d   = 1'b0;
        state_d = DONE;
      end
      MUL: begin
        acc_d    = alu_r;
        mcand_d  = mcand_q << 1;
        mplr_d   = mplr_q >> 1;
        sticky_d = sticky_q | alu_ovfl;
        step_d   = step_q + StepW'(1);
        if (step_q == LastStep) begin
          // Low WIDTH bits of the product are the same for signed and unsigned operands.
          data_d  = alu_r;
          zero_d  = (alu_r == '0);
          ovfl_d  = sticky_q | alu_ovfl;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = data_q;
  assign rsp_zero  = zero_q;
  assign rsp_ovfl  = ovfl_q;
  assign rsp_err   = err_q;

endmodule
